// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory subsystem: memory geometry,
// host-port direction constants and the dump engine state encoding.
package cpu_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   // Values driven on the host port read_write line
   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      LATCH = 3'd2,
      VALID = 3'd3,
      DONE  = 3'd4
   } dump_state_t;

endpackage

// File: rtl/mem_dump.sv
// mem_dump: streams an inclusive, wrap-around address range of the unified
// memory out over a valid/ready interface, one word every >= 3 cycles.
// Every output is a flop loaded from its *_next value, so nothing on the
// consumer side (dump_ready) reaches an output combinationally.
module mem_dump
   import cpu_pkg::*;
(
   input  logic              main_clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              mem_en,
   output logic              read_write,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] read_out_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              busy,
   output logic              done
);

   dump_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] cur_reg, cur_next;
   logic [ADDR_W-1:0] last_reg, last_next;

   logic              mem_en_reg, mem_en_next;
   logic [ADDR_W-1:0] address_reg, address_next;
   logic              dump_valid_reg, dump_valid_next;
   logic [DATA_W-1:0] dump_data_reg, dump_data_next;
   logic [ADDR_W-1:0] dump_addr_reg, dump_addr_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   // Current beat is the final one of the range (inclusive end compare)
   logic last_beat;
   assign last_beat = (cur_reg == last_reg);

   // Next-state logic; abort overrides everything outside IDLE, including
   // a beat acceptance in the same cycle
   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      last_next  = last_reg;
      if ((state_reg != IDLE) && abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  cur_next   = start_addr;
                  last_next  = end_addr;
                  state_next = ISSUE;
               end
            end
            ISSUE: state_next = LATCH;
            LATCH: state_next = VALID;
            VALID: begin
               if (dump_ready) begin
                  if (last_beat) begin
                     state_next = DONE;
                  end else begin
                     // natural 12-bit rollover gives the 0xFFF -> 0x000 wrap
                     cur_next   = cur_reg + ADDR_W'(1);
                     state_next = ISSUE;
                  end
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output next values derived from the state being entered, so each
   // output is valid in exactly the cycle its state is occupied
   always_comb begin
      mem_en_next     = (state_next == ISSUE);
      address_next    = address_reg;
      dump_valid_next = (state_next == VALID);
      dump_data_next  = dump_data_reg;
      dump_addr_next  = dump_addr_reg;
      busy_next       = (state_next != IDLE);
      done_next       = (state_next == DONE);
      if (state_next == ISSUE) begin
         address_next = cur_next;
      end
      // memory data returns during LATCH; grab it as we move to VALID
      if ((state_reg == LATCH) && (state_next == VALID)) begin
         dump_data_next = read_out_data;
         dump_addr_next = cur_reg;
      end
   end

   // FSM and range registers
   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cur_reg   <= '0;
         last_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         last_reg  <= last_next;
      end
   end

   // Memory-side output registers
   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) begin
         mem_en_reg  <= 1'b0;
         address_reg <= '0;
      end else begin
         mem_en_reg  <= mem_en_next;
         address_reg <= address_next;
      end
   end

   // Stream-side and status output registers
   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) begin
         dump_valid_reg <= 1'b0;
         dump_data_reg  <= '0;
         dump_addr_reg  <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         dump_valid_reg <= dump_valid_next;
         dump_data_reg  <= dump_data_next;
         dump_addr_reg  <= dump_addr_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
      end
   end

   assign mem_en     = mem_en_reg;
   assign read_write = MEM_READ;
   assign address    = address_reg;
   assign dump_valid = dump_valid_reg;
   assign dump_data  = dump_data_reg;
   assign dump_addr  = dump_addr_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump: a 4K x 32 memory with a host port shared through a
// busy-selected mux, a queue of expected beats built from the words the
// host wrote, and directed cycle-by-cycle literal expectations.
module tb_mem_dump;

   logic        main_clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [11:0] start_addr;
   logic [11:0] end_addr;
   logic        mem_en;
   logic        read_write;
   logic [11:0] address;
   logic [31:0] read_out_data;
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_data;
   logic [11:0] dump_addr;
   logic        busy;
   logic        done;

   mem_dump dut (
      .main_clk      (main_clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .start_addr    (start_addr),
      .end_addr      (end_addr),
      .mem_en        (mem_en),
      .read_write    (read_write),
      .address       (address),
      .read_out_data (read_out_data),
      .dump_valid    (dump_valid),
      .dump_ready    (dump_ready),
      .dump_data     (dump_data),
      .dump_addr     (dump_addr),
      .busy          (busy),
      .done          (done)
   );

   initial main_clk = 1'b0;
   always #5 main_clk = ~main_clk;

   // host side of the shared port
   logic        h_en;
   logic        h_rw;
   logic [11:0] h_addr;
   logic [31:0] h_din;

   logic        m_en;
   logic        m_rw;
   logic [11:0] m_addr;
   assign m_en   = busy ? mem_en     : h_en;
   assign m_rw   = busy ? read_write : h_rw;
   assign m_addr = busy ? address    : h_addr;

   logic [31:0] ram [4096];
   logic [31:0] rdata;
   always @(posedge main_clk) begin
      if (m_en) begin
         if (m_rw) ram[m_addr] <= h_din;
         rdata <= ram[m_addr];
      end
   end
   assign read_out_data = rdata;

   // reference contents: what the host has written
   logic [31:0] ref_mem [4096];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endfunction

   // expected beats {addr, data}, in delivery order
   logic [43:0] exp_q[$];
   bit          chk_en = 1'b0;
   bit          exp_done_nxt = 1'b0;

   // per-cycle compare against the beat queue and done expectation
   always @(negedge main_clk) begin
      if (chk_en) begin
         chk("done_pulse", 32'(done), 32'(exp_done_nxt));
         exp_done_nxt = 1'b0;
         if (dump_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(dump_addr), 32'hFFFF_FFFF);
            end else begin
               chk("beat_addr", 32'(dump_addr), 32'(exp_q[0][43:32]));
               chk("beat_data", dump_data, exp_q[0][31:0]);
               if (dump_ready) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) exp_done_nxt = 1'b1;
               end
            end
         end
      end
   end

   task automatic host_write(input logic [11:0] a, input logic [31:0] d);
      h_en = 1'b1; h_rw = 1'b1; h_addr = a; h_din = d;
      ref_mem[a] = d;
      @(posedge main_clk); #1;
      h_en = 1'b0; h_rw = 1'b0;
   endtask

   task automatic do_start(input logic [11:0] sa, input logic [11:0] ea);
      int n;
      n = int'(12'(ea - sa)) + 1;
      for (int i = 0; i < n; i++) begin
         logic [11:0] a;
         a = sa + 12'(i);
         exp_q.push_back({a, ref_mem[a]});
      end
      start = 1'b1; start_addr = sa; end_addr = ea;
      @(posedge main_clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 100) begin
         @(negedge main_clk);
         c++;
      end
      chk("done_seen", 32'(done), 32'd1);
      @(posedge main_clk); #1;
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!dump_valid && c < 50) begin
         @(negedge main_clk);
         c++;
      end
      chk("valid_seen", 32'(dump_valid), 32'd1);
   endtask

   // cycle tables for the first dump (cycles 1..8 after the start edge)
   bit e1_men  [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
   bit e1_val  [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
   bit e1_done [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   bit e1_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
   // single-beat dump (cycles 1..5)
   bit e2_done [5] = '{0, 0, 0, 1, 0};
   bit e2_busy [5] = '{1, 1, 1, 1, 0};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; end_addr = '0;
      dump_ready = 1'b0; h_en = 1'b0; h_rw = 1'b0; h_addr = '0; h_din = '0;

      // reset values
      #12;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_read_write", 32'(read_write), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_dump_valid", 32'(dump_valid), 32'd0);
      chk("rst_dump_data", dump_data, 32'd0);
      chk("rst_dump_addr", 32'(dump_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge main_clk); #1;
      reset = 1'b1;
      @(posedge main_clk); #1;
      chk_en = 1'b1;

      // two-beat dump with latency table
      host_write(12'h007, 32'h0000000a);
      host_write(12'h008, 32'h000000ff);
      dump_ready = 1'b1;
      do_start(12'h007, 12'h008);
      for (int k = 0; k < 8; k++) begin
         @(negedge main_clk);
         $display("t1 cycle %0d: mem_en=%0b valid=%0b done=%0b busy=%0b", k + 1, mem_en, dump_valid, done, busy);
         chk("t1_mem_en", 32'(mem_en), 32'(e1_men[k]));
         chk("t1_valid", 32'(dump_valid), 32'(e1_val[k]));
         chk("t1_done", 32'(done), 32'(e1_done[k]));
         chk("t1_busy", 32'(busy), 32'(e1_busy[k]));
         if (k == 0) chk("t1_address0", 32'(address), 32'h007);
         if (k == 3) chk("t1_address1", 32'(address), 32'h008);
         if (k == 2) begin
            chk("t1_beat0_addr", 32'(dump_addr), 32'h007);
            chk("t1_beat0_data", dump_data, 32'h0000000a);
         end
         if (k == 5) begin
            chk("t1_beat1_addr", 32'(dump_addr), 32'h008);
            chk("t1_beat1_data", dump_data, 32'h000000ff);
         end
      end
      @(posedge main_clk); #1;

      // single-beat range
      host_write(12'h001, 32'h18007003);
      do_start(12'h001, 12'h001);
      for (int k = 0; k < 5; k++) begin
         @(negedge main_clk);
         $display("t2 cycle %0d: valid=%0b done=%0b busy=%0b", k + 1, dump_valid, done, busy);
         chk("t2_done", 32'(done), 32'(e2_done[k]));
         chk("t2_busy", 32'(busy), 32'(e2_busy[k]));
         if (k == 2) begin
            chk("t2_beat_addr", 32'(dump_addr), 32'h001);
            chk("t2_beat_data", dump_data, 32'h18007003);
         end
      end
      @(posedge main_clk); #1;
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // back-pressure on the first beat
      host_write(12'h003, 32'h33333333);
      host_write(12'h004, 32'h44444444);
      dump_ready = 1'b0;
      do_start(12'h003, 12'h004);
      wait_valid();
      for (int k = 0; k < 5; k++) begin
         $display("t3 stall %0d: valid=%0b addr=%h data=%h", k, dump_valid, dump_addr, dump_data);
         chk("t3_hold_valid", 32'(dump_valid), 32'd1);
         chk("t3_hold_addr", 32'(dump_addr), 32'h003);
         chk("t3_hold_data", dump_data, 32'h33333333);
         @(negedge main_clk);
      end
      @(posedge main_clk); #1;
      dump_ready = 1'b1;
      wait_done();
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // range wrapping through 0xFFF
      host_write(12'hFFF, 32'hDEAD0FFF);
      host_write(12'h000, 32'hBEEF0000);
      host_write(12'h001, 32'hCAFE0001);
      do_start(12'hFFF, 12'h001);
      wait_done();
      $display("t4 wrap dump complete, beats left %0d", exp_q.size());
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // reset during the second beat
      for (int i = 0; i < 4; i++) host_write(12'h020 + 12'(i), 32'h20200000 + i);
      host_write(12'h030, 32'h30303030);
      host_write(12'h031, 32'h31313131);
      do_start(12'h020, 12'h023);
      begin
         int c = 0;
         while (exp_q.size() != 3 && c < 50) begin
            @(posedge main_clk); #1;
            c++;
         end
         chk("t5_first_beat", 32'(exp_q.size()), 32'd3);
      end
      #2;
      chk_en = 1'b0;
      reset = 1'b0;
      #1;
      $display("t5 reset: mem_en=%0b valid=%0b busy=%0b done=%0b", mem_en, dump_valid, busy, done);
      chk("t5_mem_en", 32'(mem_en), 32'd0);
      chk("t5_address", 32'(address), 32'd0);
      chk("t5_valid", 32'(dump_valid), 32'd0);
      chk("t5_dump_data", dump_data, 32'd0);
      chk("t5_dump_addr", 32'(dump_addr), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge main_clk); #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge main_clk);
         chk("t5_no_done", 32'(done), 32'd0);
         chk("t5_idle_busy", 32'(busy), 32'd0);
      end
      @(posedge main_clk); #1;
      chk_en = 1'b1;
      do_start(12'h030, 12'h031);
      wait_done();
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // start during VALID is ignored
      for (int i = 0; i < 3; i++) host_write(12'h040 + 12'(i), 32'h40400000 + i);
      host_write(12'h100, 32'h01000100);
      dump_ready = 1'b0;
      do_start(12'h040, 12'h042);
      wait_valid();
      @(posedge main_clk); #1;
      start = 1'b1; start_addr = 12'h100; end_addr = 12'h100;
      @(posedge main_clk); #1;
      start = 1'b0;
      dump_ready = 1'b1;
      wait_done();
      repeat (6) @(negedge main_clk);
      $display("t6 start-in-valid: beats left %0d busy=%0b", exp_q.size(), busy);
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);
      @(posedge main_clk); #1;

      // abort during ISSUE
      do_start(12'h007, 12'h008);
      abort = 1'b1;
      @(negedge main_clk);
      chk("t7_issue_mem_en", 32'(mem_en), 32'd1);
      @(posedge main_clk); #1;
      abort = 1'b0;
      exp_q.delete();
      @(negedge main_clk);
      $display("t7 abort: mem_en=%0b valid=%0b busy=%0b done=%0b", mem_en, dump_valid, busy, done);
      chk("t7_mem_en", 32'(mem_en), 32'd0);
      chk("t7_valid", 32'(dump_valid), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_done", 32'(done), 32'd0);
      repeat (5) @(negedge main_clk);
      @(posedge main_clk); #1;

      // normal dump after the abort
      do_start(12'h008, 12'h008);
      wait_done();
      chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
